// File: rtl/counter_cmd_seq.sv
// Command sequencer in front of the 8-bit up/down counter: buffers
// LOAD/UP/DOWN/HOLD commands in a small FIFO and expands each one into a
// cycle-exact ld_en/en/updwn/datain control sequence.
module counter_cmd_seq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [WIDTH-1:0]         cmd_arg,
   input  logic                     abort,
   output logic                     ld_en,
   output logic                     en,
   output logic                     updwn,
   output logic [WIDTH-1:0]         datain,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_e;
   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

   op_e              op_mem  [DEPTH];
   logic [WIDTH-1:0] arg_mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    count;

   state_e           state, state_d;
   op_e              op_r;
   logic [WIDTH-1:0] arg_r;
   logic [WIDTH-1:0] cnt_r;

   logic full, empty, push, pop;

   assign full       = (count == LW'(DEPTH));
   assign empty      = (count == '0);
   assign cmd_ready  = !full;
   // abort drops any push landing in the same cycle
   assign push       = cmd_valid && !full && !abort;
   assign fifo_level = count;
   assign datain     = arg_r;
   assign busy       = (state == EXEC) || !empty;

   // FIFO storage; pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr]  <= op_e'(cmd_op);
         arg_mem[wr_ptr] <= cmd_arg;
      end
   end

   // FIFO pointers and occupancy; abort flushes everything queued
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + LW'(push) - LW'(pop);
      end
   end

   // state register plus the latched command; cnt_r counts down to the last cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         op_r  <= OP_LOAD;
         arg_r <= '0;
         cnt_r <= '0;
      end else begin
         state <= state_d;
         if (pop) begin
            op_r  <= op_mem[rd_ptr];
            arg_r <= arg_mem[rd_ptr];
            // LOAD is always one cycle; N=0 still takes one cycle
            if (op_mem[rd_ptr] == OP_LOAD || arg_mem[rd_ptr] == '0)
               cnt_r <= '0;
            else
               cnt_r <= arg_mem[rd_ptr] - WIDTH'(1);
         end else if (state == EXEC && cnt_r != '0) begin
            cnt_r <= cnt_r - WIDTH'(1);
         end
      end
   end

   // next state, pop decision and control decode from registered state only
   always_comb begin
      state_d = state;
      pop     = 1'b0;
      ld_en   = 1'b0;
      en      = 1'b0;
      updwn   = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            ld_en = (op_r == OP_LOAD);
            en    = (op_r == OP_UP || op_r == OP_DOWN) && (arg_r != '0);
            updwn = (op_r == OP_UP);
            if (cnt_r == '0) begin
               done = 1'b1;
               // chain straight into the next command with no bubble
               if (!empty) pop = 1'b1;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         pop     = 1'b0;
         state_d = IDLE;
      end
   end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Scoreboard bench for counter_cmd_seq: the driver pushes a per-command
// expectation when a command is accepted; the monitor rebuilds execution
// windows from the FIFO/command rules and checks each finished command.
module tb_counter_cmd_seq;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic             abort;
   logic             ld_en, en, updwn, busy, done;
   logic [WIDTH-1:0] datain;
   logic [$clog2(DEPTH):0] fifo_level;

   counter_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .ld_en(ld_en), .en(en),
      .updwn(updwn), .datain(datain), .busy(busy), .done(done), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int en;
      int ld;
      int up;
      int data;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout/underrun expected event at %0t", nm, $time);
   endtask

   // Expected outcome of one command, straight from the command semantics
   function automatic exp_t mk(input logic [1:0] op, input logic [7:0] a);
      exp_t r;
      int   n;
      n = (a == 0) ? 1 : int'(a);
      r.data = int'(a);
      r.len = n; r.en = 0; r.ld = 0; r.up = 0;
      case (op)
         2'b00: r.len = 1;
         2'b01: begin r.en = int'(a); r.up = n; end
         2'b10: r.en = int'(a);
         default: ;
      endcase
      if (op == 2'b00) r.ld = 1;
      return r;
   endfunction

   // ---------------- monitor ----------------
   bit   exec_m;
   int   lvl_m, len_c, en_c, ld_c, up_c, maxlvl;
   bit   last_m, push_m, pop_m;
   exp_t e;

   always @(negedge clk) begin
      if (!rst_n) begin
         exec_m = 0; lvl_m = 0; len_c = 0; en_c = 0; ld_c = 0; up_c = 0;
         q.delete();
      end else begin
         chk("ready", cmd_ready, (lvl_m != DEPTH));
         chk("level", fifo_level, lvl_m);
         chk("busy", busy, (exec_m || lvl_m != 0));
         chk("ld_en_en_excl", (ld_en && en), 0);
         last_m = 0;
         if (!exec_m) begin
            chk("idle_ctl", {ld_en, en, updwn, done}, 0);
         end else if (q.size() == 0) begin
            fail("sb_underrun");
         end else begin
            len_c++; en_c += en; ld_c += ld_en; up_c += updwn;
            last_m = (len_c >= q[0].len);
            chk("done", done, last_m);
            if (last_m) begin
               e = q.pop_front();
               chk("cmd_len", len_c, e.len);
               chk("cmd_en_cycles", en_c, e.en);
               chk("cmd_ld_cycles", ld_c, e.ld);
               chk("cmd_up_cycles", up_c, e.up);
               chk("cmd_datain", datain, e.data);
               len_c = 0; en_c = 0; ld_c = 0; up_c = 0;
            end
         end
         if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
         push_m = cmd_valid && (lvl_m != DEPTH) && !abort;
         pop_m  = !abort && (lvl_m != 0) && (!exec_m || last_m);
         if (abort) begin
            exec_m = 0; lvl_m = 0; len_c = 0; en_c = 0; ld_c = 0; up_c = 0;
            q.delete();
         end else begin
            exec_m = (exec_m && !last_m) || (lvl_m != 0);
            lvl_m  = lvl_m + int'(push_m) - int'(pop_m);
         end
      end
   end

   // ---------------- driver ----------------
   // Enters and leaves aligned just after a posedge.
   task automatic send(input logic [1:0] op, input logic [7:0] arg, output int waited);
      bit acc;
      acc = 0; waited = 0;
      cmd_valid = 1; cmd_op = op; cmd_arg = arg;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge clk);
         if (cmd_ready && !abort) begin
            q.push_back(mk(op, arg));
            acc = 1;
         end else waited++;
         @(posedge clk); #1;
      end
      if (!acc) fail("send_timeout");
      cmd_valid = 0;
   endtask

   task automatic send1(input logic [1:0] op, input logic [7:0] arg);
      int w;
      send(op, arg, w);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 3000 && !ok; k++) begin
         @(negedge clk);
         if (!busy) ok = 1;
      end
      if (!ok) fail("idle_timeout");
      @(posedge clk); #1;
   endtask

   task automatic abort_cyc(input bit with_valid);
      abort = 1; cmd_valid = with_valid;
      cmd_op = 2'($urandom_range(0, 3)); cmd_arg = 8'($urandom_range(0, 9));
      @(posedge clk); #1;
      abort = 0; cmd_valid = 0;
   endtask

   initial begin
      int w, cnt;
      logic [4:0] env, upv, dnv;
      abort = 0; cmd_valid = 1; cmd_op = 2'b01; cmd_arg = 8'd5; rst_n = 0;
      maxlvl = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1; cmd_valid = 0;
      @(negedge clk);
      chk("rst_datain", datain, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_ctl", {ld_en, en, updwn, done, busy}, 0);
      @(posedge clk); #1;

      // LOAD A5: idle cycle after push, then one load cycle with done
      send1(2'b00, 8'hA5);
      @(negedge clk);
      chk("load_lat_ld0", ld_en, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("load_ld_en", ld_en, 1);
      chk("load_datain", datain, 8'hA5);
      chk("load_done", done, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("load_after_busy", busy, 0);
      @(posedge clk); #1;

      // UP 3 then DOWN 2 back to back
      send1(2'b01, 8'd3);
      send1(2'b10, 8'd2);
      env = '0; upv = '0; dnv = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         env = {env[3:0], en}; upv = {upv[3:0], updwn}; dnv = {dnv[3:0], done};
         @(posedge clk); #1;
      end
      chk("updn_en", env, 5'b11111);
      chk("updn_updwn", upv, 5'b11100);
      chk("updn_done", dnv, 5'b00101);
      wait_idle();

      // zero-argument cases and HOLD
      send1(2'b01, 8'd0);
      send1(2'b11, 8'd0);
      send1(2'b11, 8'd3);
      send1(2'b10, 8'd0);
      wait_idle();

      // longest count: no wrap of the down-counter
      send1(2'b01, 8'd255);
      wait_idle();

      // fill the FIFO behind a long command; the 5th push must stall then land
      maxlvl = 0;
      send1(2'b01, 8'd200);
      send1(2'b11, 8'd2);
      send1(2'b01, 8'd1);
      send1(2'b10, 8'd2);
      send1(2'b00, 8'h5A);
      send(2'b01, 8'd4, w);
      chk("full_maxlvl", maxlvl, DEPTH);
      chk("full_stalled", (w > 100), 1);
      wait_idle();

      // abort mid-command with two queued entries and a simultaneous push
      send1(2'b01, 8'd200);
      send1(2'b11, 8'd5);
      send1(2'b00, 8'd33);
      cnt = 0;
      for (int k = 0; k < 50 && cnt < 9; k++) begin
         @(negedge clk);
         if (en) cnt++;
         @(posedge clk); #1;
      end
      abort = 1; cmd_valid = 1; cmd_op = 2'b01; cmd_arg = 8'd9;
      @(posedge clk); #1;
      abort = 0; cmd_valid = 0;
      @(negedge clk);
      chk("abort_en", en, 0);
      chk("abort_level", fifo_level, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;

      // randomized traffic with occasional aborts and idle gaps
      for (int i = 0; i < 120; i++) begin
         int r;
         r = int'($urandom_range(0, 29));
         if (r == 0) abort_cyc(1'($urandom_range(0, 1)));
         else if (r < 6) begin @(posedge clk); #1; end
         else if (r < 10) send1(2'b00, 8'($urandom_range(0, 255)));
         else send1(2'($urandom_range(1, 3)), 8'($urandom_range(0, 6)));
      end
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 8-bit up/down counter and drives its ld_en/en/updwn/datain controls. It accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and buffers them in a small FIFO. Each command is expanded into a cycle-exact control sequence. It lets the test environment or a host issue "count up N steps" instead of toggling the counter's pins every cycle.

Parameters:
WIDTH, 8, data/argument width; matches counter datain.
DEPTH, 4, command FIFO entries; power of 2, >=2.

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; = !full
cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 HOLD
cmd_arg  input  WIDTH  LOAD: value; UP/DOWN/HOLD: cycle count N
abort  input  1  flush FIFO, cancel current command
ld_en  output  1  counter load enable
en  output  1  counter count enable
updwn  output  1  1=up, 0=down
datain  output  WIDTH  counter load data
busy  output  1  EXEC state or FIFO non-empty
done  output  1  1-cycle pulse on last cycle of each command
fifo_level  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, state IDLE, all outputs 0; fifo_level=0, cmd_ready=1 after reset. Reset mid-command discards it with no done pulse.
- Push: cmd_valid && cmd_ready at posedge. cmd_ready is combinational !full only. A valid held while full waits and is not dropped.
- Pop: in IDLE with FIFO non-empty, or in the last EXEC cycle with FIFO non-empty. The head is latched into op_r and arg_r, cnt_r = max(arg,1)-1, and state becomes EXEC.
- Push and pop in the same cycle: level unchanged. Pop from 1 entry plus push: the pushed entry is retained.
- Controls are decoded only from registered state (op_r, arg_r, state). There is no combinational cmd_* to control path.
- Latency: a command pushed at edge T into an empty FIFO while IDLE is popped at T+1. Its controls are active in the cycle after edge T+1.
- FSM IDLE: ld_en=en=done=0. The transition to EXEC happens on pop.
- FSM EXEC:
  - LOAD: exactly 1 cycle, ld_en=1, en=0, datain=arg_r.
  - UP/DOWN with N>=1: N cycles, en=1; updwn=1 for UP, 0 for DOWN.
  - UP/DOWN with N=0: 1 cycle, en=0 (no-op).
  - HOLD: max(N,1) cycles, en=0, ld_en=0.
  - cnt_r decrements each cycle. The last cycle is cnt_r==0, with done=1 in that cycle. The next state is EXEC if FIFO non-empty, else IDLE.
  - Back-to-back commands have no bubble.
- datain = arg_r at all times; arg_r resets to 0 and updates on every pop.
- updwn = 1 only in EXEC with op UP, else 0.
- ld_en and en are never both 1.
- abort (sampled at posedge, lower priority than reset):
  - FIFO cleared, state IDLE, ld_en=en=done=0 from the next cycle.
  - A push in the same cycle is dropped.
  - No done is issued for the aborted command.
- N=255 with WIDTH=8 gives 255 en cycles; cnt_r never wraps.
- fifo_level range is 0..DEPTH. Pointers wrap modulo DEPTH.

Test Plan:
- Reset: hold rst_n=0 3 cycles with cmd_valid=1 -> no push; ld_en=en=updwn=done=0, datain=0, fifo_level=0, cmd_ready=1 after release.
- LOAD 8'hA5 pushed at edge T -> in the cycle after T+1: ld_en=1, datain=8'hA5, done=1 for exactly 1 cycle; then IDLE, busy=0.
- UP 3 then DOWN 2 pushed on consecutive cycles -> en=1 for 5 consecutive cycles; updwn=1,1,1,0,0; done pulses on cycles 3 and 5; no gap between the two commands.
- Full FIFO: push UP 200, then 4 more commands -> fifo_level reaches 4, cmd_ready=0; a 5th cmd_valid is held until a pop, then accepted and not lost.
- Abort: during UP 200 at en-cycle 10 with 2 entries queued, assert abort together with cmd_valid -> next cycle en=0, fifo_level=0, busy=0, no done pulse, pushed command dropped.
- Zero args: UP 0 -> 1 EXEC cycle with en=0, done=1. HOLD 0 -> 1 cycle. HOLD 3 -> 3 cycles en=0, done on the 3rd.
